seq_divider: RTL

//   Multi-cycle unsigned restoring divider. It is the inverse of the team's

---
 rtl/seq_divider.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider -- multi-cycle unsigned restoring divider.
//
// Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit
// divisor, one quotient bit per clock, with a start/done handshake.
//
// Optional feature macro: DIV_ZERO_ERR_EN
//   defined   -> err port exists; a zero divisor skips the iteration and
//                finishes one cycle after acceptance with err=1.
//   undefined -> no err port; a zero divisor runs the normal WIDTH steps.
//   In both builds a zero divisor yields quotient=all ones, remainder=dividend.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   start      in   1      request, sampled only in IDLE or DONE
//   dividend   in   WIDTH  captured on the accepting edge
//   divisor    in   WIDTH  captured on the accepting edge
//   busy       out  1      high while iterating
//   done       out  1      one-cycle pulse, results valid from this cycle
//   quotient   out  WIDTH  result, held until the next result
//   remainder  out  WIDTH  result, held until the next result
//   err        out  1      divide-by-zero flag (DIV_ZERO_ERR_EN only)
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_rem;    // partial remainder
    logic [WIDTH-1:0] r_dvd;    // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_accept;
    logic             w_zero_skip;
    logic             w_last;

    // Because the partial remainder stays below the divisor, the shifted
    // value is below 2*divisor; the trial's top bit is therefore a clean
    // borrow flag (1 = negative, keep the shifted remainder).
    always_comb begin
        w_shift   = {r_rem, r_dvd[WIDTH-1]};
        w_trial   = w_shift - {1'b0, r_dvs};
        w_ge      = ~w_trial[WIDTH];
        w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_q_nxt   = {r_dvd[WIDTH-2:0], w_ge};
    end

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_ERR_EN
    assign w_zero_skip = (divisor == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_remo  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept && w_zero_skip) begin
                        r_state <= S_DONE;
                        r_quot  <= '1;
                        r_remo  <= dividend;
                    end else if (w_accept) begin
                        r_state <= S_BUSY;
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_quot  <= w_q_nxt;
                        r_remo  <= w_rem_nxt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DIV_ZERO_ERR_EN
    logic r_err;

    // Every accepted start re-evaluates the flag, so a good operation clears it.
    always_ff @(posedge clk) begin
        if (rst)           r_err <= 1'b0;
        else if (w_accept) r_err <= w_zero_skip;
    end

    assign err = r_err;
`endif

    assign busy      = (r_state == S_BUSY);
    assign done      = (r_state == S_DONE);
    assign quotient  = r_quot;
    assign remainder = r_remo;

endmodule
